tree_walk_ctrl: RTL and testbench
=================================

TREE_WALK_CTRL -- requirements
Module: tree_walk_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the node-memory address width.
REQ-003 Parameter ROOT_ADDR, default 0, SHALL set the first node fetched.
REQ-004 Parameter MAX_DEPTH, default 32, SHALL set the node-visit limit per walk.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  walk request.
REQ-008 start_ready  out  1  high only in IDLE.
REQ-009 feat  in  32  four unsigned 8-bit features {a1,a2,a3,a4}, a1 in bits [31:24].
REQ-010 mem_addr  out  ADDR_WIDTH  node address, shared by the coefficient and child memories.
REQ-011 mem_rd  out  1  read strobe.
REQ-012 coef_rdata  in  48  node coefficients {c1,c2,c3,c4,c5,c6}, each 8 bits, c1 in [47:40].
REQ-013 child_rdata  in  18  {left[17:9], right[8:0]}.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  result accepted.
REQ-016 out_class  out  8  class id.
REQ-017 out_err  out  1  depth overflow.
REQ-018 out_depth  out  6  number of nodes visited.

Function
REQ-019 The state machine SHALL have states IDLE, FETCH, EVAL and DONE, plus MAC when TREE_WALK_PIPE_MAC_EN is defined.
REQ-020 In IDLE, start=1 SHALL latch feat, set node=ROOT_ADDR and depth=0, and enter FETCH on the next edge.
REQ-021 In FETCH, mem_addr=node and mem_rd=1 for exactly one cycle, with the rdata buses valid in the following cycle (memory read latency 1).
REQ-022 In EVAL, sum SHALL be a1*c1+a2*c2+a3*c3+a4*c4+c5, computed unsigned on 18 bits with no overflow; c5 is the bias and c6 the threshold.
REQ-023 The walk SHALL take ptr=left when sum < {10'b0,c6}, and ptr=right otherwise (equality goes right).
REQ-024 Each EVAL SHALL increment depth by 1.
REQ-025 ptr[8]=1 is a leaf: out_class=ptr[7:0] and next state DONE.
REQ-026 ptr[8]=0 is an internal node: node=ptr[ADDR_WIDTH-1:0], with ptr bits [7:ADDR_WIDTH] ignored, and next state FETCH.
REQ-027 Reaching depth==MAX_DEPTH with no leaf found SHALL cause DONE with out_err=1 and out_class=0.
REQ-028 In DONE, out_valid=1 and out_class, out_err and out_depth SHALL be held stable until out_ready=1, after which DONE->IDLE.
REQ-029 start SHALL be ignored outside IDLE; start and out_ready high together in DONE SHALL give only the return to IDLE.
REQ-030 Latency from the start-accept edge to out_valid SHALL be 2*d+1 cycles for d nodes visited (3*d+1 with the macro).
REQ-031 mem_rd SHALL be 0 in every state other than FETCH.

Reset
REQ-032 rst_n low SHALL, immediately and in any state, force IDLE and set out_valid=0, mem_rd=0, mem_addr=0, out_class=0, out_err=0, out_depth=0 and start_ready=1 after release.
REQ-033 A reset during a walk SHALL discard the walk, and the next start SHALL behave as after power-up.

Configuration
REQ-034 When TREE_WALK_PIPE_MAC_EN is defined, the block SHALL register the sum in state MAC (FETCH->MAC->EVAL), so each node takes 3 cycles.
REQ-035 When TREE_WALK_PIPE_MAC_EN is undefined, the product, sum and compare SHALL be combinational within EVAL, at 2 cycles per node; results SHALL be identical in both builds.

Structure
REQ-036 Package tree_walk_pkg SHALL hold the state enum, the coefficient and child field-slice constants, LEAF_BIT=8 and SUM_W=18.
REQ-037 Sub-module tree_walk_dot SHALL hold the 4-term multiply-accumulate plus bias, and the controller SHALL contain the FSM, depth counter and result registers.

Verification
REQ-038 Root-leaf scenario: feat=01010101, root c1..c4=1, c5=0, c6=5, left=9'h103 -> out_class=3, out_depth=1, out_err=0, out_valid 3 cycles after the start-accept edge.
REQ-039 Equality scenario: sum==c6 (feat=02020202, c=1, c6=8), right=9'h107 -> out_class=7.
REQ-040 Extremes scenario: feat=FFFFFFFF, c1..c5=FF, c6=FF -> sum=260355 with no wrap, right branch taken.
REQ-041 Self-loop scenario: root left=right=9'h000 -> out_err=1, out_depth=32, out_valid 65 cycles after start-accept.
REQ-042 Reset scenario: rst_n pulsed low during EVAL of a 3-deep walk -> all outputs 0 at once, and a following start yields the correct class.
REQ-043 Backpressure scenario: out_ready low for 5 cycles in DONE with start held high -> outputs stable, start_ready=0, IDLE entered one cycle after out_ready=1.

Source files
------------

// File: rtl/tree_walk_pkg.sv
// Shared state encoding, field slices and widths for the decision-tree walker.
// Defining TREE_WALK_PIPE_MAC_EN adds the MAC pipeline state.
package tree_walk_pkg;

    localparam int FEAT_W          = 8;
    localparam int COEF_W          = 8;
    localparam int SUM_W           = 18;
    localparam int LEAF_BIT        = 8;
    localparam int PTR_W           = 9;
    localparam int CHILD_LEFT_MSB  = 17;
    localparam int CHILD_LEFT_LSB  = 9;
    localparam int CHILD_RIGHT_MSB = 8;
    localparam int CHILD_RIGHT_LSB = 0;
    localparam int COEF_BIAS_IDX   = 4;
    localparam int COEF_THR_IDX    = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_DONE  = 3'd3
`ifdef TREE_WALK_PIPE_MAC_EN
        , ST_MAC = 3'd4
`endif
    } state_e;

    // Index 0 is the most significant byte (c1 / a1).
    function automatic logic [COEF_W-1:0] coef_field(input logic [47:0] coef, input int idx);
        return coef[47 - COEF_W*idx -: COEF_W];
    endfunction

    function automatic logic [FEAT_W-1:0] feat_field(input logic [31:0] feat, input int idx);
        return feat[31 - FEAT_W*idx -: FEAT_W];
    endfunction

endpackage

// File: rtl/tree_walk_dot.sv
// Node score: four unsigned 8x8 products plus the node bias.
module tree_walk_dot
    import tree_walk_pkg::*;
(
    input  logic [31:0]      feat_i,
    input  logic [47:0]      coef_i,
    output logic [SUM_W-1:0] sum_o
);

    // 18 bits hold the all-ones worst case (4*255*255+255) without wrapping.
    always_comb begin
        sum_o = SUM_W'(coef_field(coef_i, COEF_BIAS_IDX));
        for (int i = 0; i < 4; i++) begin
            sum_o = sum_o + SUM_W'(feat_field(feat_i, i)) * SUM_W'(coef_field(coef_i, i));
        end
    end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walk controller: fetches nodes, compares score to threshold, reports leaf class.
// Build option TREE_WALK_PIPE_MAC_EN registers the score in a MAC state (3 cycles per node).
module tree_walk_ctrl
    import tree_walk_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int ROOT_ADDR  = 0,
    parameter int MAX_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  start_ready,
    input  logic [31:0]           feat,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [47:0]           coef_rdata,
    input  logic [17:0]           child_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_class,
    output logic                  out_err,
    output logic [5:0]            out_depth
);

    state_e                state_q, state_d;
    logic [31:0]           feat_q, feat_d;
    logic [ADDR_WIDTH-1:0] node_q, node_d;
    logic [5:0]            depth_q, depth_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_class_q, out_class_d;
    logic                  out_err_q, out_err_d;
    logic [5:0]            out_depth_q, out_depth_d;
    logic                  start_ready_q, start_ready_d;

    logic [SUM_W-1:0]      sum_s;
    logic [SUM_W-1:0]      eval_sum_s;
    logic [COEF_W-1:0]     eval_thr_s;
    logic [17:0]           eval_child_s;
    logic [PTR_W-1:0]      ptr_s;
    logic [5:0]            depth_inc_s;

    tree_walk_dot u_dot (
        .feat_i (feat_q),
        .coef_i (coef_rdata),
        .sum_o  (sum_s)
    );

`ifdef TREE_WALK_PIPE_MAC_EN
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [COEF_W-1:0] thr_q, thr_d;
    logic [17:0]       child_q, child_d;

    assign eval_sum_s   = sum_q;
    assign eval_thr_s   = thr_q;
    assign eval_child_s = child_q;
`else
    assign eval_sum_s   = sum_s;
    assign eval_thr_s   = coef_field(coef_rdata, COEF_THR_IDX);
    assign eval_child_s = child_rdata;
`endif

    assign depth_inc_s = depth_q + 6'd1;

    // Branch select: strictly below threshold goes left, equality goes right.
    always_comb begin
        if (eval_sum_s < {10'b0, eval_thr_s}) begin
            ptr_s = eval_child_s[CHILD_LEFT_MSB:CHILD_LEFT_LSB];
        end else begin
            ptr_s = eval_child_s[CHILD_RIGHT_MSB:CHILD_RIGHT_LSB];
        end
    end

    // Next-state, walk bookkeeping and result capture.
    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        node_d      = node_q;
        depth_d     = depth_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;
        out_depth_d = out_depth_q;
`ifdef TREE_WALK_PIPE_MAC_EN
        sum_d       = sum_q;
        thr_d       = thr_q;
        child_d     = child_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    feat_d  = feat;
                    node_d  = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d = 6'd0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
`ifdef TREE_WALK_PIPE_MAC_EN
                state_d = ST_MAC;
`else
                state_d = ST_EVAL;
`endif
            end
`ifdef TREE_WALK_PIPE_MAC_EN
            ST_MAC: begin
                sum_d   = sum_s;
                thr_d   = coef_field(coef_rdata, COEF_THR_IDX);
                child_d = child_rdata;
                state_d = ST_EVAL;
            end
`endif
            ST_EVAL: begin
                depth_d = depth_inc_s;
                if (ptr_s[LEAF_BIT]) begin
                    out_class_d = ptr_s[7:0];
                    out_err_d   = 1'b0;
                    out_depth_d = depth_inc_s;
                    state_d     = ST_DONE;
                end else if (depth_inc_s == 6'(MAX_DEPTH)) begin
                    out_class_d = 8'd0;
                    out_err_d   = 1'b1;
                    out_depth_d = depth_inc_s;
                    state_d     = ST_DONE;
                end else begin
                    node_d  = ptr_s[ADDR_WIDTH-1:0];
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_rd_d      = (state_d == ST_FETCH);
        out_valid_d   = (state_d == ST_DONE);
        start_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset clears everything and parks in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            feat_q        <= 32'd0;
            node_q        <= '0;
            depth_q       <= 6'd0;
            mem_rd_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_class_q   <= 8'd0;
            out_err_q     <= 1'b0;
            out_depth_q   <= 6'd0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            feat_q        <= feat_d;
            node_q        <= node_d;
            depth_q       <= depth_d;
            mem_rd_q      <= mem_rd_d;
            out_valid_q   <= out_valid_d;
            out_class_q   <= out_class_d;
            out_err_q     <= out_err_d;
            out_depth_q   <= out_depth_d;
            start_ready_q <= start_ready_d;
        end
    end

`ifdef TREE_WALK_PIPE_MAC_EN
    // Pipelined score, threshold and child pointers captured in MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            thr_q   <= 8'd0;
            child_q <= 18'd0;
        end else begin
            sum_q   <= sum_d;
            thr_q   <= thr_d;
            child_q <= child_d;
        end
    end
`endif

    assign mem_addr    = node_q;
    assign mem_rd      = mem_rd_q;
    assign out_valid   = out_valid_q;
    assign out_class   = out_class_q;
    assign out_err     = out_err_q;
    assign out_depth   = out_depth_q;
    assign start_ready = start_ready_q;

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Self-checking bench for tree_walk_ctrl: directed scenarios plus random trees vs a walk model.
module tb_tree_walk_ctrl;

    localparam int AW   = 6;
    localparam int ROOT = 0;
    localparam int MAXD = 32;
`ifdef TREE_WALK_PIPE_MAC_EN
    localparam int CPN = 3;
`else
    localparam int CPN = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] feat = 32'd0;
    logic        start_ready;
    logic [AW-1:0] mem_addr;
    logic        mem_rd;
    logic [47:0] coef_rdata;
    logic [17:0] child_rdata;
    logic        out_valid;
    logic [7:0]  out_class;
    logic        out_err;
    logic [5:0]  out_depth;

    logic [47:0] coef_mem [64];
    logic [17:0] child_mem [64];

    int n_vec = 0;
    int n_bad = 0;

    int          exp_path [$];
    logic [7:0]  e_cls;
    logic        e_err;
    int          e_depth;
    int          e_lat;
    bit          active = 1'b0;
    int          cyc = 0;

    tree_walk_ctrl #(.ADDR_WIDTH(AW), .ROOT_ADDR(ROOT), .MAX_DEPTH(MAXD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .feat        (feat),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .coef_rdata  (coef_rdata),
        .child_rdata (child_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_err     (out_err),
        .out_depth   (out_depth)
    );

    always #5 clk = ~clk;

    // Node memory with one-cycle read latency; data is scrambled when not read.
    always @(posedge clk) begin
        if (mem_rd) begin
            coef_rdata  <= coef_mem[mem_addr];
            child_rdata <= child_mem[mem_addr];
        end else begin
            coef_rdata  <= 48'({$urandom(), $urandom()});
            child_rdata <= 18'($urandom());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_sum(input logic [31:0] f, input logic [47:0] c);
        int s;
        s = int'(c[15:8]);
        for (int i = 0; i < 4; i++) begin
            s = s + int'(f[31-8*i -: 8]) * int'(c[47-8*i -: 8]);
        end
        return s;
    endfunction

    // Walk the tree held in the bench memories; records the node visit order.
    task automatic model_walk(input logic [31:0] f, output logic [7:0] cls,
                              output logic err, output int depth);
        int node;
        node = ROOT;
        exp_path.delete();
        cls = 8'd0;
        err = 1'b1;
        depth = 0;
        for (int d = 1; d <= MAXD; d++) begin
            int s;
            int ptr;
            exp_path.push_back(node);
            s = model_sum(f, coef_mem[node]);
            if (s < int'(coef_mem[node][7:0])) ptr = int'(child_mem[node][17:9]);
            else                               ptr = int'(child_mem[node][8:0]);
            depth = d;
            if (ptr >= 256) begin
                cls = 8'(ptr);
                err = 1'b0;
                return;
            end
            node = ptr % 64;
        end
    endtask

    // Per-cycle comparison of the DUT against the model while a walk is in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (active) begin
                cyc++;
                if (mem_rd) begin
                    if (exp_path.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL extra_fetch: read of addr 0x%0h in cycle %0d, expected none", mem_addr, cyc);
                    end else begin
                        chk("mem_addr", 32'(mem_addr), 32'(exp_path.pop_front()));
                    end
                end
                chk("start_ready_busy", 32'(start_ready), 32'd0);
                if (cyc < e_lat) begin
                    chk("out_valid_early", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_valid", 32'(out_valid), 32'd1);
                    chk("out_class", 32'(out_class), 32'(e_cls));
                    chk("out_err", 32'(out_err), 32'(e_err));
                    chk("out_depth", 32'(out_depth), 32'(e_depth));
                end
            end
        end
    end

    task automatic run_walk(input logic [31:0] f, input int hold, input bit hold_start);
        model_walk(f, e_cls, e_err, e_depth);
        e_lat = CPN * e_depth + 1;
        @(negedge clk);
        feat = f;
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        active = 1'b1;
        start = hold_start;
        feat = $urandom();
        repeat (e_lat + hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        active = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("fetch_count", 32'(exp_path.size()), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_start_ready", 32'(start_ready), 32'd1);
    endtask

    task automatic fill_random(input bit wide);
        for (int n = 0; n < 64; n++) begin
            logic [8:0] l;
            logic [8:0] r;
            if (wide) begin
                coef_mem[n] = 48'({$urandom(), $urandom()});
            end else begin
                coef_mem[n] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                               8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                               8'($urandom_range(0, 31)), 8'($urandom_range(0, 255))};
            end
            l = {($urandom_range(0, 3) == 0), 8'($urandom())};
            r = {($urandom_range(0, 3) == 0), 8'($urandom())};
            child_mem[n] = {l, r};
        end
    endtask

    initial begin
        logic [7:0] pc;
        logic       pe;
        int         pd;
        logic [31:0] f;

        for (int n = 0; n < 64; n++) begin
            coef_mem[n]  = 48'd0;
            child_mem[n] = 18'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_class", 32'(out_class), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_depth", 32'(out_depth), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);

        // Root is a leaf on the left
        coef_mem[0]  = 48'h01010101_0005;
        child_mem[0] = {9'h103, 9'h1AA};
        model_walk(32'h01010101, pc, pe, pd);
        chk("pin_root_class", 32'(pc), 32'd3);
        chk("pin_root_depth", 32'(pd), 32'd1);
        run_walk(32'h01010101, 0, 1'b0);

        // Sum equal to threshold goes right
        coef_mem[0]  = 48'h01010101_0008;
        child_mem[0] = {9'h1EE, 9'h107};
        model_walk(32'h02020202, pc, pe, pd);
        chk("pin_equal_class", 32'(pc), 32'd7);
        run_walk(32'h02020202, 1, 1'b0);

        // Extreme operands: no wrap, right branch; with backpressure and start held
        coef_mem[0]  = 48'hFFFFFFFF_FFFF;
        child_mem[0] = {9'h1BB, 9'h142};
        chk("pin_max_sum", 32'(model_sum(32'hFFFFFFFF, 48'hFFFFFFFFFFFF)), 32'd260355);
        model_walk(32'hFFFFFFFF, pc, pe, pd);
        chk("pin_max_class", 32'(pc), 32'h42);
        run_walk(32'hFFFFFFFF, 5, 1'b1);

        // Self-loop hits the depth limit
        coef_mem[0]  = 48'h0;
        child_mem[0] = {9'h000, 9'h000};
        model_walk(32'h5A5A5A5A, pc, pe, pd);
        chk("pin_loop_err", 32'(pe), 32'd1);
        chk("pin_loop_depth", 32'(pd), 32'd32);
        run_walk(32'h5A5A5A5A, 0, 1'b0);

        // Three-deep walk (bits above the address are ignored), reset mid-walk
        coef_mem[0]  = 48'h00000000_0001;
        child_mem[0] = {9'h005, 9'h1F0};
        coef_mem[5]  = 48'h00000000_0001;
        child_mem[5] = {9'h0C9, 9'h1F1};
        coef_mem[9]  = 48'h00000000_0001;
        child_mem[9] = {9'h15A, 9'h1F2};
        f = 32'h12345678;
        model_walk(f, pc, pe, pd);
        chk("pin_deep_class", 32'(pc), 32'h5A);
        chk("pin_deep_depth", 32'(pd), 32'd3);
        run_walk(32'h0, 0, 1'b0);
        @(negedge clk);
        feat = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2 * CPN - 1) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_out_class", 32'(out_class), 32'd0);
        chk("mid_rst_out_err", 32'(out_err), 32'd0);
        chk("mid_rst_out_depth", 32'(out_depth), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_start_ready", 32'(start_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        run_walk(f, 0, 1'b0);

        // Random trees and features
        for (int it = 0; it < 40; it++) begin
            bit wide;
            wide = (it % 4 == 3);
            fill_random(wide);
            if (wide) f = $urandom();
            else      f = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)),
                           8'($urandom_range(0, 31)), 8'($urandom_range(0, 31))};
            run_walk(f, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
